// File: rtl/color_selector.sv
// Button/switch front end for the overlay colour selects: sync, debounce, index
// update, registered one-hot. Optional auto-advance under COLOR_AUTO_CYCLE_EN.

module color_selector_debounce #(
    parameter int DB_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic {REL, PRS} db_state_t;

    db_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          press_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REL;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            press <= press_n;
        end
    end

    // Flip only on the cycle after the counter has already reached DB_CYCLES
    // and the level still disagrees.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        press_n = 1'b0;
        if (level != (state == PRS)) begin
            if (cnt == CW'(DB_CYCLES)) begin
                state_n = (state == REL) ? PRS : REL;
                press_n = (state == REL);
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end
endmodule

module color_selector #(
    parameter int DB_CYCLES   = 2000000,
    parameter int RESET_IDX   = 7
`ifdef COLOR_AUTO_CYCLE_EN
    ,
    parameter int AUTO_CYCLES = 100000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_load,
    input  logic [2:0] sw_color,
`ifdef COLOR_AUTO_CYCLE_EN
    input  logic       auto_en,
`endif
    output logic       Black,
    output logic       Blue,
    output logic       Green,
    output logic       Cyan,
    output logic       Red,
    output logic       Magenta,
    output logic       Yellow,
    output logic       White,
    output logic [2:0] color_idx,
    output logic       changed
);
`ifdef COLOR_AUTO_CYCLE_EN
    localparam int NUM_SYNC = 7;
`else
    localparam int NUM_SYNC = 6;
`endif

    logic [NUM_SYNC-1:0] raw, sync1, sync2;
    logic [2:0]          press;
    logic [2:0]          sw_s;
    logic                next_req;
    logic [2:0]          idx, idx_n;
    logic [7:0]          sel;

    assign raw[5:0] = {sw_color, btn_load, btn_prev, btn_next};
`ifdef COLOR_AUTO_CYCLE_EN
    assign raw[6] = auto_en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sw_s = sync2[5:3];

    // press[0]=next, press[1]=prev, press[2]=load
    color_selector_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
        .clk   (clk),
        .reset (reset),
        .level (sync2[2:0]),
        .press (press)
    );

`ifdef COLOR_AUTO_CYCLE_EN
    localparam int AW = $clog2(AUTO_CYCLES + 1);

    logic [AW-1:0] auto_cnt;
    logic          auto_tick;

    // A manual press or load in the wrap cycle swallows the auto advance.
    assign auto_tick = sync2[6] && (auto_cnt == AW'(AUTO_CYCLES - 1)) && !(|press);

    always_ff @(posedge clk) begin
        if (reset || !sync2[6] || (|press))
            auto_cnt <= '0;
        else if (auto_cnt == AW'(AUTO_CYCLES - 1))
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + 1'b1;
    end

    assign next_req = press[0] | auto_tick;
`else
    assign next_req = press[0];
`endif

    always_comb begin
        idx_n = idx;
        if (press[2])
            idx_n = sw_s;
        else if (next_req && !press[1])
            idx_n = idx + 3'd1;
        else if (press[1] && !next_req)
            idx_n = idx - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= 3'(RESET_IDX);
            sel     <= 8'b1 << 3'(RESET_IDX);
            changed <= 1'b0;
        end else begin
            idx     <= idx_n;
            sel     <= 8'b1 << idx_n;
            changed <= (idx_n != idx);
        end
    end

    assign color_idx = idx;
    assign {White, Yellow, Magenta, Red, Cyan, Green, Blue, Black} = sel;
endmodule

// File: tb/tb_color_selector.sv
// Directed bench for color_selector with DB_CYCLES=4, RESET_IDX=7.

module tb_color_selector;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next, btn_prev, btn_load;
    logic [2:0] sw_color;
`ifdef COLOR_AUTO_CYCLE_EN
    logic       auto_en;
`endif
    logic       Black, Blue, Green, Cyan, Red, Magenta, Yellow, White;
    logic [2:0] color_idx;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int chg_total = 0;
    int chg_base;

    color_selector #(
        .DB_CYCLES (4),
        .RESET_IDX (7)
`ifdef COLOR_AUTO_CYCLE_EN
        ,
        .AUTO_CYCLES (8)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .btn_load  (btn_load),
        .sw_color  (sw_color),
`ifdef COLOR_AUTO_CYCLE_EN
        .auto_en   (auto_en),
`endif
        .Black     (Black),
        .Blue      (Blue),
        .Green     (Green),
        .Cyan      (Cyan),
        .Red       (Red),
        .Magenta   (Magenta),
        .Yellow    (Yellow),
        .White     (White),
        .color_idx (color_idx),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (changed === 1'b1) chg_total++;

    typedef struct {
        logic       nxt;
        logic       prv;
        logic       ld;
        logic [2:0] sw;
        int         exp_idx;
        int         exp_chg;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int onehot();
        return int'({White, Yellow, Magenta, Red, Cyan, Green, Blue, Black});
    endfunction

    task automatic chk_idx(input string nm, input int exp);
        chk({nm, " idx"}, int'(color_idx), exp);
        chk({nm, " onehot"}, onehot(), 1 << exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 1, "next 0->1"};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'b000, 0, 1, "prev 1->0"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b000, 7, 1, "prev wrap 0->7"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'b100, 4, 1, "load red"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'b100, 4, 0, "load same"};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b100, 4, 0, "next+prev"};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'b010, 2, 1, "load beats both"};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b101, 5, 1, "load beats next"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b101, 6, 1, "next 5->6"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b101, 7, 1, "next 6->7"};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b101, 0, 1, "next wrap 7->0"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 3'b000, 0, 0, "load black same"};

        reset = 1'b1; btn_next = 0; btn_prev = 0; btn_load = 0; sw_color = 3'b000;
`ifdef COLOR_AUTO_CYCLE_EN
        auto_en = 1'b0;
`endif
        tick(3);
        reset = 1'b0;
        chk_idx("reset", 7);
        chk("reset changed", int'(changed), 0);
        chg_base = chg_total;
        tick(20);
        chk_idx("idle", 7);
        chk("idle changed", chg_total - chg_base, 0);

        // Exact latency: raw high sampled on edge k, update on edge k+7.
        chg_base = chg_total;
        btn_next = 1'b1;
        tick(7);
        chk_idx("latency early", 7);
        chk("latency early changed", int'(changed), 0);
        tick(1);
        chk_idx("latency wrap", 0);
        chk("latency changed hi", int'(changed), 1);
        tick(1);
        chk("latency changed lo", int'(changed), 0);
        tick(10);
        chk_idx("held no repeat", 0);
        chk("held pulses", chg_total - chg_base, 1);
        btn_next = 1'b0;
        tick(12);

        for (int i = 0; i < 12; i++) begin
            chg_base = chg_total;
            btn_next = vecs[i].nxt;
            btn_prev = vecs[i].prv;
            btn_load = vecs[i].ld;
            sw_color = vecs[i].sw;
            tick(12);
            btn_next = 0; btn_prev = 0; btn_load = 0;
            tick(12);
            chk_idx(vecs[i].name, vecs[i].exp_idx);
            chk({vecs[i].name, " changed"}, chg_total - chg_base, vecs[i].exp_chg);
        end

        // Bouncing prev: 3 high / 2 low never reaches the debounce count.
        chg_base = chg_total;
        for (int r = 0; r < 10; r++) begin
            btn_prev = 1'b1;
            tick(3);
            btn_prev = 1'b0;
            tick(2);
        end
        tick(10);
        chk_idx("bounce", 0);
        chk("bounce changed", chg_total - chg_base, 0);

        // Reset mid-debounce, button still held afterwards.
        btn_next = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chg_base = chg_total;
        tick(7);
        chk_idx("post-reset early", 7);
        tick(1);
        chk_idx("post-reset advance", 0);
        tick(10);
        chk_idx("post-reset single", 0);
        chk("post-reset pulses", chg_total - chg_base, 1);
        btn_next = 1'b0;
        tick(12);

`ifdef COLOR_AUTO_CYCLE_EN
        auto_en = 1'b1;
        tick(9);
        chk_idx("auto early", 0);
        tick(1);
        chk_idx("auto first", 1);
        tick(7);
        chk_idx("auto hold", 1);
        tick(1);
        chk_idx("auto second", 2);
        btn_next = 1'b1;
        tick(8);
        chk_idx("auto manual", 3);
        tick(7);
        chk_idx("auto after manual hold", 3);
        tick(1);
        chk_idx("auto after manual", 4);
        auto_en = 1'b0;
        btn_next = 1'b0;
        tick(12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
